a2d_scheduler: RTL
==================

Name: a2d_scheduler

Overview:
- Sequences the shared A2D SPI master through a fixed round-robin of four analog channels: battery, motor current, brake and pedal torque.
- Each channel read is a two-transaction SPI exchange (command, then readback). The block holds registered 12-bit results for the rest of the eBike core.
- Sits between the SPI master and the sensor-condition/telemetry logic.
- Paces conversions with an interval timer, guards every transaction with a watchdog, and pulses when a full round completes.

Parameters:
- FAST_SIM, 1, selects the interval between conversions: 1 => 2^8 clk, 0 => 2^14 clk.
- TIMEOUT, 1024, max clk cycles to wait for SPI done before abandoning a transaction.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  enables scheduling; when low, finishes the current channel, then idles
- wrt  out  1  one-cycle pulse to SPI master: start transaction
- cmd  out  16  SPI command word, valid while wrt=1
- done  in  1  one-cycle pulse from SPI master: transaction finished
- resp  in  16  SPI receive word, valid on done
- batt  out  12  latest battery reading
- curr  out  12  latest current reading
- brake  out  12  latest brake reading
- torque  out  12  latest torque reading
- rnd_cmplt  out  1  one-cycle pulse when all four channels have been refreshed in a round
- err  out  1  sticky timeout flag; cleared only by rst

Behaviour:
- Reset: every output is 0, the state is IDLE, the channel index is 0, and the interval timer is cleared.
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on posedge clk. rst mid-transaction aborts immediately and wrt stays 0; a late done is ignored.
- Channel order and numbers: index 0..3 maps to channel numbers 0 (batt), 1 (curr), 3 (brake), 4 (torque), then wraps to 0.
- Command word: cmd = {2'b00, chnl[2:0], 11'h000} for both transactions.
- States:
  - IDLE: the interval timer counts while en=1. At terminal count, go to CMD. If en=0, the timer holds at 0.
  - CMD: wrt=1 for exactly one cycle, then go to WAIT1.
  - WAIT1: on done, go to GAP. The first response is discarded.
  - GAP: one idle cycle, so the SPI master sees SS_n deasserted. Then go to RD.
  - RD: wrt=1 for one cycle, then go to WAIT2.
  - WAIT2: on done, latch resp[11:0] into the indexed result register on that same posedge. Advance the index and go to IDLE.
- rnd_cmplt: asserted the cycle after the torque result latches (index wraps 3->0).
- Result latency: a result is visible 1 clk after done.
- Watchdog: a counter runs in WAIT1 and WAIT2 and resets on each wrt. At TIMEOUT:
  - set err;
  - leave the result register unchanged;
  - advance the index and return to IDLE;
  - do not assert rnd_cmplt for that round.
- done outside WAIT1/WAIT2 is ignored.
- done arriving on the same cycle as wrt cannot occur; the SPI master guarantees at least 1 cycle.
- en dropped mid-channel: the current channel completes both transactions, then the block stays in IDLE.
- Interval timer width is 14 bits, used for both FAST_SIM settings. It resets to 0 on entering IDLE.

Decomposition:
- eBike_pkg holds:
  - the state enum a2d_state_t (IDLE, CMD, WAIT1, GAP, RD, WAIT2);
  - the localparam channel map CH_BATT=3'd0, CH_CURR=3'd1, CH_BRAKE=3'd3, CH_TORQUE=3'd4;
  - the command-format helper function.
- One sub-module, a2d_watchdog: a loadable counter with a timeout pulse output.
- The FSM, interval timer and result registers stay in a2d_scheduler.

Test Plan:
- Reset check: rst=1 for 3 clk with an SPI master model attached -> all outputs 0, no wrt.
- Single round, FAST_SIM=1, en=1, resp=16'h0ABC, done 40 clk after each wrt:
  - first wrt at clk 256 with cmd=16'h0000;
  - second wrt with cmd=16'h0000;
  - batt=12'hABC 1 clk after the second done.
- Full round, model returns 12'h111, 12'h222, 12'h333, 12'h444 per channel:
  - cmds are 16'h0000, 16'h0800, 16'h1800, 16'h2000 in order;
  - batt/curr/brake/torque match;
  - exactly one rnd_cmplt pulse;
  - the index wraps to channel 0.
- Timeout: no done after the curr CMD ->
  - err=1 at 1024 clk;
  - curr unchanged;
  - the next wrt targets brake (cmd=16'h1800);
  - no rnd_cmplt that round.
- en dropped during WAIT1 of brake -> brake still completes and latches, then no wrt for 2^14 clk. Raising en resumes with torque.
- Mid-operation reset: rst asserted during WAIT2 with done 1 clk later -> results stay 0, state IDLE, err=0.

Source files
------------

// File: rtl/eBike_pkg.sv
// rtl/eBike_pkg.sv - shared A2D scheduler types, channel map and command helpers
package eBike_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WAIT1 = 3'd2,
    GAP   = 3'd3,
    RD    = 3'd4,
    WAIT2 = 3'd5
  } a2d_state_t;

  localparam logic [2:0] CH_BATT   = 3'd0;
  localparam logic [2:0] CH_CURR   = 3'd1;
  localparam logic [2:0] CH_BRAKE  = 3'd3;
  localparam logic [2:0] CH_TORQUE = 3'd4;

  // Round-robin slot to physical A2D channel number.
  function automatic logic [2:0] chnl_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return CH_BATT;
      2'd1:    return CH_CURR;
      2'd2:    return CH_BRAKE;
      default: return CH_TORQUE;
    endcase
  endfunction

  // Both the command and the readback transaction carry the same word.
  function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_watchdog.sv
// rtl/a2d_watchdog.sv - loadable transaction watchdog with timeout pulse
module a2d_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic tmo
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Count waiting cycles since the last transaction start; reload on each start.
  always_ff @(posedge clk) begin
    if (rst || load) cnt <= '0;
    else if (run && !tmo) cnt <= cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th waiting cycle.
  assign tmo = run && (cnt == LAST);

endmodule

// File: rtl/a2d_scheduler.sv
// rtl/a2d_scheduler.sv - round-robin A2D channel sequencer for the shared SPI master
module a2d_scheduler
  import eBike_pkg::*;
#(
  parameter int FAST_SIM = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        rnd_cmplt,
  output logic        err
);

  localparam logic [13:0] TERM = (FAST_SIM != 0) ? 14'd255 : 14'h3FFF;

  a2d_state_t  state, nxt;
  logic [1:0]  idx;
  logic [13:0] tmr;
  logic        tmo;
  logic        round_bad;
  logic        in_wait;
  logic        rd_ok;
  logic        abandon;
  logic        advance;
  logic        unused_resp_hi;

  assign in_wait        = (state == WAIT1) || (state == WAIT2);
  assign rd_ok          = (state == WAIT2) && done;
  assign abandon        = tmo && !done;
  assign advance        = rd_ok || abandon;
  assign unused_resp_hi = ^resp[15:12];

  a2d_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .load (wrt),
    .run  (in_wait),
    .tmo  (tmo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end

  // Next-state and transaction-start decode.
  always_comb begin
    nxt = state;
    wrt = 1'b0;
    case (state)
      IDLE:  if (en && tmr == TERM) nxt = CMD;
      CMD:   begin wrt = 1'b1; nxt = WAIT1; end
      WAIT1: if (done) nxt = GAP; else if (tmo) nxt = IDLE;
      GAP:   nxt = RD;
      RD:    begin wrt = 1'b1; nxt = WAIT2; end
      WAIT2: if (done || tmo) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign cmd = wrt ? a2d_cmd(chnl_of(idx)) : 16'h0000;

  // Interval timer: counts enabled IDLE cycles, cleared everywhere else.
  always_ff @(posedge clk) begin
    if (rst || state != IDLE || !en || tmr == TERM) tmr <= '0;
    else tmr <= tmr + 14'd1;
  end

  // Result registers: readback latched on the done of the second transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      batt   <= '0;
      curr   <= '0;
      brake  <= '0;
      torque <= '0;
    end else if (rd_ok) begin
      case (idx)
        2'd0:    batt   <= resp[11:0];
        2'd1:    curr   <= resp[11:0];
        2'd2:    brake  <= resp[11:0];
        default: torque <= resp[11:0];
      endcase
    end
  end

  // Channel index, sticky error and round-complete tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 2'd0;
      err       <= 1'b0;
      rnd_cmplt <= 1'b0;
      round_bad <= 1'b0;
    end else begin
      rnd_cmplt <= rd_ok && (idx == 2'd3) && !round_bad;
      if (abandon) err <= 1'b1;
      if (advance) idx <= idx + 2'd1;
      if (advance && idx == 2'd3) round_bad <= 1'b0;
      else if (abandon) round_bad <= 1'b1;
    end
  end

endmodule
